// File: rtl/arb_mux.sv
// N-channel registered word multiplexer with valid/ready handshaking.
// Channel choice comes from an explicit select (MODE=0) or a round-robin search (MODE=1).
module arb_mux #(
  parameter int BITS     = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS-1:0]      in_valid,
  input  logic [CHANNELS*BITS-1:0] in_data,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [SELW-1:0]          select,
  output logic                     out_valid,
  output logic [BITS-1:0]          out_data,
  output logic [SELW-1:0]          out_chan,
  input  logic                     out_ready,
  output logic                     sel_err
);

  logic            out_valid_reg;
  logic [BITS-1:0] out_data_reg;
  logic [SELW-1:0] out_chan_reg;
  logic            sel_err_reg;
  logic [SELW-1:0] rr_last_reg;

  logic            can_accept;
  logic            sel_ok;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] scan;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic            xfer;
  logic [BITS-1:0] data_sel;
  logic [BITS-1:0] words [CHANNELS];

  assign can_accept = !out_valid_reg || out_ready;

  // One extra bit keeps the range test meaningful when CHANNELS is a power of two.
  assign sel_ok = ({1'b0, select} < (SELW+1)'(CHANNELS));

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    scan     = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      scan = SELW'((int'(rr_last_reg) + k) % CHANNELS);
      if (!rr_found && in_valid[scan]) begin
        rr_found = 1'b1;
        rr_idx   = scan;
      end
    end
  end

  assign grant_vld = (MODE == 1) ? rr_found : sel_ok;
  assign grant_idx = (MODE == 1) ? rr_idx   : select;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign words[gi]    = in_data[gi*BITS +: BITS];
      assign in_ready[gi] = can_accept && grant_vld && (grant_idx == SELW'(gi));
    end
  endgenerate

  // AND-OR mux driven by the one-hot ready keeps out_data X-free for bad selects.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_ready[k]) data_sel = data_sel | words[k];
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      sel_err_reg   <= 1'b0;
      rr_last_reg   <= SELW'(CHANNELS - 1);
    end else begin
      sel_err_reg <= (MODE == 0) && !sel_ok;
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= data_sel;
        out_chan_reg  <= grant_idx;
        if (MODE == 1) rr_last_reg <= grant_idx;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: three instances (select/4ch, select/3ch, round-robin/4ch)
// driven together, with a reference model feeding a scoreboard queue.
module tb_arb_mux;
  localparam int NI = 3;

  typedef struct {
    int          inst;
    int          chan;
    logic [15:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  v    [NI];
  logic [63:0] d    [NI];
  logic [1:0]  s    [NI];
  logic        ordy [NI];

  logic [3:0]  irdy [NI];
  logic        ov   [NI];
  logic [15:0] od   [NI];
  logic [1:0]  oc   [NI];
  logic        se   [NI];

  logic [3:0]  ir0, ir2;
  logic [2:0]  ir1;
  logic        ov0, ov1, ov2, se0, se1, se2;
  logic [15:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;

  arb_mux #(.BITS(16), .CHANNELS(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_data(d[0]), .in_ready(ir0),
    .select(s[0]), .out_valid(ov0), .out_data(od0), .out_chan(oc0),
    .out_ready(ordy[0]), .sel_err(se0));

  arb_mux #(.BITS(16), .CHANNELS(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[1][2:0]), .in_data(d[1][47:0]), .in_ready(ir1),
    .select(s[1]), .out_valid(ov1), .out_data(od1), .out_chan(oc1),
    .out_ready(ordy[1]), .sel_err(se1));

  arb_mux #(.BITS(16), .CHANNELS(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_data(d[2]), .in_ready(ir2),
    .select(s[2]), .out_valid(ov2), .out_data(od2), .out_chan(oc2),
    .out_ready(ordy[2]), .sel_err(se2));

  always_comb begin
    irdy[0] = ir0; irdy[1] = {1'b0, ir1}; irdy[2] = ir2;
    ov[0] = ov0;   ov[1] = ov1;   ov[2] = ov2;
    od[0] = od0;   od[1] = od1;   od[2] = od2;
    oc[0] = oc0;   oc[1] = oc1;   oc[2] = oc2;
    se[0] = se0;   se[1] = se1;   se[2] = se2;
  end

  txn_t sbq [$];
  int   rr_m   [NI];
  bit   hold_m [NI];
  bit   se_m   [NI];
  int   total = 0;
  int   bad   = 0;

  function automatic int chans_of(input int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic int mode_of(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  // Channel the rules award this cycle, or -1 when nothing is granted.
  function automatic int grant_of(input int k);
    if (mode_of(k) == 0)
      return (int'(s[k]) < chans_of(k)) ? int'(s[k]) : -1;
    for (int j = 1; j <= chans_of(k); j++) begin
      int i;
      i = (rr_m[k] + j) % chans_of(k);
      if (v[k][i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", nm, k, act, exp);
    end
  endtask

  // Reference model: decides each edge which word (if any) must appear at the output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbq.delete();
      for (int k = 0; k < NI; k++) begin
        hold_m[k] = 1'b0;
        rr_m[k]   = chans_of(k) - 1;
        se_m[k]   = 1'b0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int   g;
        bit   can;
        txn_t t;
        g   = grant_of(k);
        can = !hold_m[k] || ordy[k];
        se_m[k] = (mode_of(k) == 0) && (int'(s[k]) >= chans_of(k));
        if (can && g >= 0 && v[k][g]) begin
          t.inst = k;
          t.chan = g;
          t.data = d[k][g*16 +: 16];
          sbq.push_back(t);
          hold_m[k] = 1'b1;
          if (mode_of(k) == 1) rr_m[k] = g;
        end else if (ordy[k]) begin
          hold_m[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: checks handshake outputs and pops the scoreboard on each consumed word.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        int         g;
        int         idx;
        logic [3:0] eir;
        g   = grant_of(k);
        eir = ((!hold_m[k] || ordy[k]) && g >= 0) ? 4'(1 << g) : 4'b0;
        chk("in_ready", k, 64'(irdy[k]), 64'(eir));
        chk("out_valid", k, 64'(ov[k]), 64'(hold_m[k]));
        chk("sel_err", k, 64'(se[k]), 64'(se_m[k]));
        if (ov[k] && ordy[k]) begin
          idx = -1;
          for (int j = 0; j < sbq.size(); j++)
            if (idx < 0 && sbq[j].inst == k) idx = j;
          if (idx < 0) begin
            chk("unexpected_word", k, 64'd1, 64'd0);
          end else begin
            $display("txn inst=%0d chan=%0d data=%h", k, oc[k], od[k]);
            chk("out_chan", k, 64'(oc[k]), 64'(sbq[idx].chan));
            chk("out_data", k, 64'(od[k]), 64'(sbq[idx].data));
            sbq.delete(idx);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      v[k] = '0; d[k] = '0; s[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_out_valid", k, 64'(ov[k]), 64'd0);
      chk("rst_out_data", k, 64'(od[k]), 64'd0);
      chk("rst_out_chan", k, 64'(oc[k]), 64'd0);
      chk("rst_sel_err", k, 64'(se[k]), 64'd0);
    end
    chk("rst_in_ready_rr", 2, 64'(irdy[2]), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_in_ready_rr", 2, 64'(irdy[2]), 64'd0);

    // Explicit select of channel 2.
    v[0] = 4'hF;
    d[0] = {16'hA0A3, 16'hA0A2, 16'hA0A1, 16'hA0A0};
    s[0] = 2'd2;
    #1 chk("sel_in_ready", 0, 64'(irdy[0]), 64'h4);
    step();
    chk("sel_out_valid", 0, 64'(ov[0]), 64'd1);
    chk("sel_out_data", 0, 64'(od[0]), 64'hA0A2);
    chk("sel_out_chan", 0, 64'(oc[0]), 64'd2);
    v[0] = '0;

    // Out-of-range select on the 3-channel instance.
    v[1] = 4'h7;
    s[1] = 2'd3;
    #1 chk("badsel_in_ready", 1, 64'(irdy[1]), 64'd0);
    repeat (3) begin
      step();
      chk("badsel_err", 1, 64'(se[1]), 64'd1);
      chk("badsel_out_valid", 1, 64'(ov[1]), 64'd0);
    end
    s[1] = 2'd0;
    v[1] = '0;
    step();
    chk("badsel_err_clear", 1, 64'(se[1]), 64'd0);

    // Round-robin rotation with every channel requesting.
    v[2] = 4'hF;
    d[2] = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_rotate_chan", 2, 64'(oc[2]), 64'(i % 4));
    end
    v[2] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_sparse_chan", 2, 64'(oc[2]), (i % 2 == 0) ? 64'd1 : 64'd3);
    end

    // Backpressure: hold 16'h1234, then drain and refill on one edge.
    v[2] = 4'b0001;
    d[2] = {16'h0, 16'h0, 16'h5678, 16'h1234};
    step();
    chk("bp_load", 2, 64'(od[2]), 64'h1234);
    ordy[2] = 1'b0;
    v[2] = 4'hF;
    #1 chk("bp_in_ready", 2, 64'(irdy[2]), 64'd0);
    repeat (3) begin
      step();
      chk("bp_hold_data", 2, 64'(od[2]), 64'h1234);
      chk("bp_hold_ready", 2, 64'(irdy[2]), 64'd0);
    end
    ordy[2] = 1'b1;
    #1 chk("bp_release_ready", 2, 64'(irdy[2]), 64'h2);
    step();
    chk("bp_refill_valid", 2, 64'(ov[2]), 64'd1);
    chk("bp_refill_chan", 2, 64'(oc[2]), 64'd1);
    chk("bp_refill_data", 2, 64'(od[2]), 64'h5678);

    // Randomised traffic on all instances.
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NI; k++) begin
        v[k]    = 4'($urandom) & ((k == 1) ? 4'h7 : 4'hF);
        d[k]    = {$urandom, $urandom};
        s[k]    = 2'($urandom_range(0, 3));
        ordy[k] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    // Asynchronous reset while a word is stalled.
    for (int k = 0; k < NI; k++) begin
      v[k] = '0; s[k] = '0; ordy[k] = 1'b1;
    end
    v[2] = 4'hF;
    step();
    ordy[2] = 1'b0;
    step();
    chk("mid_pre_valid", 2, 64'(ov[2]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 2, 64'(ov[2]), 64'd0);
    chk("mid_rst_data", 2, 64'(od[2]), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ordy[2] = 1'b1;
    step();
    chk("mid_first_valid", 2, 64'(ov[2]), 64'd1);
    chk("mid_first_chan", 2, 64'(oc[2]), 64'd0);

    for (int k = 0; k < NI; k++) begin
      v[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) step();
    chk("drain_empty", 0, 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel registered multiplexer with valid/ready handshaking, the successor to the plain 2:1 word select in the RISC datapath. It chooses one of CHANNELS input words per cycle, either by an explicit select or by round-robin arbitration, and holds the chosen word in a one-entry output register that drains under backpressure. It sits between multiple producers (register-file read ports, forwarding paths, bus masters) and a single consumer stage.

## Interface
- BITS, 16: data word width.
- CHANNELS, 4: number of input channels, 2..16; SELW = $clog2(CHANNELS) is derived, not a parameter.
- MODE, 0: 0 = explicit select, 1 = round-robin arbitration (select ignored).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  CHANNELS  per-channel word offered.
- in_data  in  CHANNELS*BITS  channel i occupies bits [i*BITS +: BITS].
- in_ready  out  CHANNELS  per-channel accept, at most one bit high (one-hot or zero).
- select  in  SELW  channel index, used only when MODE=0.
- out_valid  out  1  output register holds a word.
- out_data  out  BITS  registered word.
- out_chan  out  SELW  channel index the word came from.
- out_ready  in  1  consumer accepts the word.
- sel_err  out  1  registered one-cycle flag: MODE=0 and select >= CHANNELS.

## Operation
- Reset values: out_valid=0, out_data=0, out_chan=0, sel_err=0, rr_last=CHANNELS-1, so channel 0 has first priority.
- can_accept = !out_valid || out_ready.
- Grant in MODE=0:
  - grant = select when select < CHANNELS.
  - Otherwise no grant: all in_ready=0, and sel_err is set next cycle. Invalid selects never produce an X on out_data.
- Grant in MODE=1:
  - Search upward from rr_last+1, wrapping modulo CHANNELS.
  - The first channel with in_valid=1 is granted.
  - No valid channel means no grant.
- in_ready[g] = can_accept && (grant exists). This is combinational; it depends on in_valid, select, out_valid and out_ready only, never on in_ready.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. At the clock edge:
  - out_data <= word g, out_chan <= g, out_valid <= 1.
  - In MODE=1, rr_last <= g.
- rr_last changes only on a transfer. An offered but unaccepted request does not advance the pointer.
- When out_valid && out_ready and there is no new transfer, out_valid <= 0. out_data and out_chan hold their stale value.
- Simultaneous drain and fill: out_valid stays 1 and the register loads the new word. This gives full throughput of one word per cycle.
- While out_valid && !out_ready:
  - out_data and out_chan are held stable.
  - All in_ready are 0.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants rotate 0,1,...,CHANNELS-1,0. Each channel waits at most CHANNELS-1 transfers.
- Producers may drop in_valid before a grant; no state is affected.
- Reset mid-transfer discards the held word (out_valid=0) and restores rr_last.

## Timing
- Latency: 1 cycle from input handshake to out_valid/out_data.
- Throughput: 1 word/cycle while out_ready=1.
- Combinational paths:
  - in_valid/select/out_ready -> in_ready.
  - No combinational path from any input to out_valid, out_data, out_chan or sel_err.
- sel_err: high for exactly the cycle after each cycle in which select >= CHANNELS (MODE=0). It is always 0 in MODE=1.
- Asynchronous reset takes effect immediately and is released synchronously by the surrounding reset synchroniser.

## Test plan
- Reset/idle: hold rst_n=0, then release with all in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=4'b0000 every cycle.
- Explicit select (MODE=0, BITS=16, CHANNELS=4):
  - Stimulus: in_valid=4'b1111, data i = 16'hA0A0+i, out_ready=1, select=2.
  - Required: in_ready=4'b0100; next cycle out_data=16'hA0A2, out_chan=2, out_valid=1.
- Invalid select: CHANNELS=3, select=3, in_valid=3'b111 -> in_ready=0, out_valid stays 0, sel_err=1 for exactly one cycle after each offending cycle.
- Round-robin (MODE=1):
  - Stimulus: all 4 channels valid, out_ready=1 for 8 cycles.
  - Required: out_chan sequence 0,1,2,3,0,1,2,3.
  - Then with only in_valid[1] and in_valid[3] high: grants alternate 1,3,1,3.
- Backpressure:
  - Stimulus: a word 16'h1234 is loaded, then out_ready=0 for 3 cycles.
  - Required: out_data=16'h1234 stable, in_ready=0, rr_last unchanged.
  - Then out_ready=1 with a new request -> drain and refill in the same edge, out_valid stays 1.
- Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 before the next edge; after release, the first round-robin grant goes to channel 0.
